// File: rtl/hbm_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : hbm_req_arbiter
// Description : Shares one HBM command port among NUM_REQ requesters.
//               The arbiter chooses a requester by round-robin, and high-
//               priority requests are considered first. It issues the
//               command to the HBM port. It then holds the port until the
//               matching completion returns or a watchdog expires.
//               Sticky error flags are exported for status reporting.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   req_valid_i      : command pending, one bit per requester
//   req_prio_i       : high-priority qualifier, one bit per requester
//   req_wr_i         : 1 = write, 0 = read, one bit per requester
//   req_addr_i       : packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_len_i        : packed burst lengths, requester i at [i*LEN_W +: LEN_W]
//   req_ready_o      : one-hot accept (combinational, IDLE only)
//   cmd_valid_o      : command presented to the HBM port
//   cmd_ready_i      : HBM port accepts the command
//   cmd_addr_o/len/wr/id : registered command fields
//   cpl_valid_i      : completion strobe from the HBM port
//   cpl_id_i         : completion tag
//   cpl_err_i        : HBM reported error
//   done_o           : one-cycle completion pulse per requester
//   done_err_o       : qualifies done_o (HBM error or watchdog)
//   busy_o           : arbiter not idle
//   timeout_err_o    : sticky watchdog flag
//   stray_cpl_o      : sticky unexpected-completion flag
// ============================================================================
module hbm_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 33,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 4096,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_prio_i,
  input  logic [NUM_REQ-1:0]        req_wr_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      cmd_valid_o,
  input  logic                      cmd_ready_i,
  output logic [ADDR_W-1:0]         cmd_addr_o,
  output logic [LEN_W-1:0]          cmd_len_o,
  output logic                      cmd_wr_o,
  output logic [ID_W-1:0]           cmd_id_o,
  input  logic                      cpl_valid_i,
  input  logic [ID_W-1:0]           cpl_id_i,
  input  logic                      cpl_err_i,
  output logic [NUM_REQ-1:0]        done_o,
  output logic                      done_err_o,
  output logic                      busy_o,
  output logic                      timeout_err_o,
  output logic                      stray_cpl_o
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [ID_W-1:0]   ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_CPL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [LEN_W-1:0]    cmd_len_q, cmd_len_d;
  logic                cmd_wr_q, cmd_wr_d;
  logic [ID_W-1:0]     cmd_id_q, cmd_id_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic                done_err_q, done_err_d;
  logic                timeout_err_q, timeout_err_d;
  logic                stray_q, stray_d;

  // Unpack the flat request buses so the winner can be selected by index.
  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [LEN_W-1:0]  len_arr  [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr_i[gi*ADDR_W +: ADDR_W];
      assign len_arr[gi]  = req_len_i[gi*LEN_W +: LEN_W];
    end
  endgenerate

  // Priority qualifies the candidate set. Then a single rotating search
  // starting after last_grant picks the winner. Priority grants therefore
  // advance the same pointer.
  logic [NUM_REQ-1:0] prio_set;
  logic [NUM_REQ-1:0] cand;
  logic               win_found;
  logic [ID_W-1:0]    win_idx;

  assign prio_set = req_valid_i & req_prio_i;
  assign cand     = (|prio_set) ? prio_set : req_valid_i;

  always_comb begin : p_pick
    int              idx;
    logic [ID_W-1:0] idx_id;
    idx       = 0;
    idx_id    = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_id = ID_W'(idx);
      if (!win_found && cand[idx_id]) begin
        win_found = 1'b1;
        win_idx   = idx_id;
      end
    end
  end

  always_comb begin : p_next
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_len_d     = cmd_len_q;
    cmd_wr_d      = cmd_wr_q;
    cmd_id_d      = cmd_id_q;
    cnt_d         = cnt_q;
    done_d        = '0;
    done_err_d    = 1'b0;
    timeout_err_d = timeout_err_q;
    stray_d       = stray_q;
    req_ready_o   = '0;

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          req_ready_o[win_idx] = 1'b1;
          cmd_addr_d           = addr_arr[win_idx];
          cmd_len_d            = len_arr[win_idx];
          cmd_wr_d             = req_wr_i[win_idx];
          cmd_id_d             = win_idx;
          last_grant_d         = win_idx;
          state_d              = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready_i) begin
          cnt_d   = '0;
          state_d = ST_WAIT_CPL;
        end
      end
      ST_WAIT_CPL: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        // A matching completion takes precedence over a watchdog that
        // expires in the same cycle.
        if (cpl_valid_i && (cpl_id_i == cmd_id_q)) begin
          done_d[cmd_id_q] = 1'b1;
          done_err_d       = cpl_err_i;
          state_d          = ST_IDLE;
        end else if (cnt_q >= CNT_LAST) begin
          done_d[cmd_id_q] = 1'b1;
          done_err_d       = 1'b1;
          timeout_err_d    = 1'b1;
          state_d          = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A completion is expected only while waiting, and only with the
    // outstanding tag. Any other completion is recorded and then dropped.
    if (cpl_valid_i && !((state_q == ST_WAIT_CPL) && (cpl_id_i == cmd_id_q)))
      stray_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= ID_LAST;
      cmd_addr_q    <= '0;
      cmd_len_q     <= '0;
      cmd_wr_q      <= 1'b0;
      cmd_id_q      <= '0;
      cnt_q         <= '0;
      done_q        <= '0;
      done_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      stray_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_len_q     <= cmd_len_d;
      cmd_wr_q      <= cmd_wr_d;
      cmd_id_q      <= cmd_id_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      done_err_q    <= done_err_d;
      timeout_err_q <= timeout_err_d;
      stray_q       <= stray_d;
    end
  end

  assign cmd_valid_o   = (state_q == ST_ISSUE);
  assign busy_o        = (state_q != ST_IDLE);
  assign cmd_addr_o    = cmd_addr_q;
  assign cmd_len_o     = cmd_len_q;
  assign cmd_wr_o      = cmd_wr_q;
  assign cmd_id_o      = cmd_id_q;
  assign done_o        = done_q;
  assign done_err_o    = done_err_q;
  assign timeout_err_o = timeout_err_q;
  assign stray_cpl_o   = stray_q;

endmodule
`default_nettype wire

// File: tb/tb_hbm_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_hbm_req_arbiter
// Description : Directed self-checking bench for hbm_req_arbiter
//               (NUM_REQ=4, TIMEOUT=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hbm_req_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 33;
  localparam int LEN_W   = 8;
  localparam int TIMEOUT = 16;
  localparam int ID_W    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid, req_prio, req_wr, req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic                      cmd_valid, cmd_ready, cmd_wr;
  logic [ADDR_W-1:0]         cmd_addr;
  logic [LEN_W-1:0]          cmd_len;
  logic [ID_W-1:0]           cmd_id, cpl_id;
  logic                      cpl_valid, cpl_err;
  logic [NUM_REQ-1:0]        done;
  logic                      done_err, busy, timeout_err, stray_cpl;

  hbm_req_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .LEN_W   (LEN_W),
    .TIMEOUT (TIMEOUT),
    .ID_W    (ID_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid),
    .req_prio_i    (req_prio),
    .req_wr_i      (req_wr),
    .req_addr_i    (req_addr),
    .req_len_i     (req_len),
    .req_ready_o   (req_ready),
    .cmd_valid_o   (cmd_valid),
    .cmd_ready_i   (cmd_ready),
    .cmd_addr_o    (cmd_addr),
    .cmd_len_o     (cmd_len),
    .cmd_wr_o      (cmd_wr),
    .cmd_id_o      (cmd_id),
    .cpl_valid_i   (cpl_valid),
    .cpl_id_i      (cpl_id),
    .cpl_err_i     (cpl_err),
    .done_o        (done),
    .done_err_o    (done_err),
    .busy_o        (busy),
    .timeout_err_o (timeout_err),
    .stray_cpl_o   (stray_cpl)
  );

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] a_tab [NUM_REQ];
  logic [LEN_W-1:0]  l_tab [NUM_REQ];
  logic [NUM_REQ-1:0] wr_tab;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: grant in IDLE, one ISSUE cycle, immediate cmd_ready,
  // immediate completion, then check the done pulse.
  task automatic do_cmd(input int id, input logic [3:0] v, input logic [3:0] p,
                        input logic err);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    req_valid = v;
    req_prio  = p;
    #1;
    chk("grant", req_ready, oh);
    tick();
    req_valid = '0;
    req_prio  = '0;
    chk("issue_valid", cmd_valid, 1);
    chk("issue_id", cmd_id, id);
    chk("issue_addr", cmd_addr, a_tab[id]);
    chk("issue_len", cmd_len, l_tab[id]);
    chk("issue_wr", cmd_wr, wr_tab[id]);
    chk("ready_low", req_ready, 0);
    chk("done_one_cycle", done, 0);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("wait_busy", busy, 1);
    chk("wait_cmd_valid", cmd_valid, 0);
    cpl_valid = 1'b1;
    cpl_id    = ID_W'(id);
    cpl_err   = err;
    tick();
    cpl_valid = 1'b0;
    cpl_err   = 1'b0;
    chk("done", done, oh);
    chk("done_err", done_err, err);
    chk("idle_after_done", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    a_tab[0] = 33'h1_0000_0000;
    a_tab[1] = 33'h0_0000_1000;
    a_tab[2] = 33'h0_ABCD_E000;
    a_tab[3] = 33'h1_FFFF_FFC0;
    l_tab[0] = 8'h10;
    l_tab[1] = 8'h20;
    l_tab[2] = 8'h30;
    l_tab[3] = 8'hFF;
    wr_tab   = 4'b1010;

    rst       = 1'b1;
    req_valid = '0;
    req_prio  = '0;
    req_wr    = wr_tab;
    req_addr  = {a_tab[3], a_tab[2], a_tab[1], a_tab[0]};
    req_len   = {l_tab[3], l_tab[2], l_tab[1], l_tab[0]};
    cmd_ready = 1'b0;
    cpl_valid = 1'b0;
    cpl_id    = '0;
    cpl_err   = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_busy", busy, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    chk("rst_cmd_id", cmd_id, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_stray", stray_cpl, 0);
    chk("rst_ready", req_ready, 0);

    // Round-robin with all requesters active: 0,1,2,3,0
    do_cmd(0, 4'b1111, 4'b0000, 1'b0);
    do_cmd(1, 4'b1111, 4'b0000, 1'b0);
    do_cmd(2, 4'b1111, 4'b0000, 1'b0);
    do_cmd(3, 4'b1111, 4'b0000, 1'b0);
    do_cmd(0, 4'b1111, 4'b0000, 1'b0);

    // Priority: last_grant=1, requesters 0 and 2 with 2 high priority
    do_cmd(1, 4'b0010, 4'b0000, 1'b0);
    do_cmd(2, 4'b0101, 4'b0100, 1'b0);
    do_cmd(0, 4'b0101, 4'b0000, 1'b0);

    // Backpressure: last_grant=0, requester 3 only
    req_valid = 4'b1000;
    #1;
    chk("bp_grant", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    for (int i = 0; i < 10; i++) begin
      chk("bp_cmd_valid", cmd_valid, 1);
      chk("bp_cmd_addr", cmd_addr, a_tab[3]);
      tick();
    end
    chk("bp_cmd_valid_11", cmd_valid, 1);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("bp_wait_busy", busy, 1);
    chk("bp_wait_cmd_valid", cmd_valid, 0);
    cpl_valid = 1'b1;
    cpl_id    = 2'd3;
    tick();
    cpl_valid = 1'b0;
    chk("bp_done", done, 4'b1000);

    // Watchdog: last_grant=3 so requester 0 wins after wrap
    req_valid = 4'b0001;
    #1;
    chk("to_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("to_no_done_early", done, 0);
    end
    tick();
    chk("to_done", done, 4'b0001);
    chk("to_done_err", done_err, 1);
    chk("to_timeout_err", timeout_err, 1);
    chk("to_idle", busy, 0);
    chk("to_no_stray_yet", stray_cpl, 0);
    tick();
    chk("to_done_pulse", done, 0);
    chk("to_sticky", timeout_err, 1);
    cpl_valid = 1'b1;
    cpl_id    = 2'd0;
    tick();
    cpl_valid = 1'b0;
    chk("late_cpl_stray", stray_cpl, 1);
    chk("late_cpl_no_done", done, 0);

    // Reset while waiting: last_grant=0, requester 2 only
    req_valid = 4'b0100;
    #1;
    chk("rw_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    chk("rw_wait_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_busy", busy, 0);
    chk("rw_cmd_valid", cmd_valid, 0);
    chk("rw_done", done, 0);
    chk("rw_timeout_err", timeout_err, 0);
    chk("rw_stray", stray_cpl, 0);
    chk("rw_cmd_id", cmd_id, 0);

    // After reset requester 0 wins; mismatched then erroring completion
    req_valid = 4'b1111;
    #1;
    chk("mm_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    cpl_valid = 1'b1;
    cpl_id    = 2'd3;
    tick();
    cpl_valid = 1'b0;
    chk("mm_stray", stray_cpl, 1);
    chk("mm_no_done", done, 0);
    chk("mm_still_wait", busy, 1);
    cpl_valid = 1'b1;
    cpl_id    = 2'd0;
    cpl_err   = 1'b1;
    tick();
    cpl_valid = 1'b0;
    cpl_err   = 1'b0;
    chk("mm_done", done, 4'b0001);
    chk("mm_done_err", done_err, 1);
    chk("mm_idle", busy, 0);
    chk("mm_no_timeout", timeout_err, 0);

    // Completion on the last watchdog cycle wins: last_grant=0, requester 1
    req_valid = 4'b0010;
    #1;
    chk("edge_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    repeat (15) tick();
    chk("edge_still_busy", busy, 1);
    chk("edge_no_done", done, 0);
    cpl_valid = 1'b1;
    cpl_id    = 2'd1;
    tick();
    cpl_valid = 1'b0;
    chk("edge_done", done, 4'b0010);
    chk("edge_done_err", done_err, 0);
    chk("edge_no_timeout", timeout_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
